// File: rtl/decode_in_capture_pkg.sv
// Shared types and constants for the decode-stage input capture block.
// Record layout: {enable, instr, npc, ts}, MSB first.
package decode_in_capture_pkg;

    localparam int unsigned REC_DATA_W = 16;
    localparam int unsigned REC_TS_W   = 32;
    localparam logic [7:0]  OVF_MAX    = 8'd255;

    typedef enum logic [1:0] {
        ENABLED = 2'b00,
        ALL     = 2'b01,
        CHANGE  = 2'b10
    } capture_mode_e;

    typedef struct packed {
        logic                  enable;
        logic [REC_DATA_W-1:0] instr;
        logic [REC_DATA_W-1:0] npc;
        logic [REC_TS_W-1:0]   ts;
    } decode_in_rec_t;

endpackage

// File: rtl/decode_in_capture_if.sv
// Monitored decode inputs, control and record drain port of decode_in_capture.
interface decode_in_capture_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TS_W   = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              clear;
    logic              capture_en;
    logic [1:0]        mode;
    logic              enable_decode;
    logic [DATA_W-1:0] Instr_dout;
    logic [DATA_W-1:0] npc_in;
    logic              rec_valid;
    logic              rec_ready;
    logic              rec_enable;
    logic [DATA_W-1:0] rec_instr;
    logic [DATA_W-1:0] rec_npc;
    logic [TS_W-1:0]   rec_ts;
    logic [CNT_W-1:0]  count;
    logic [7:0]        overflow_cnt;

    modport master (
        output clear, capture_en, mode, enable_decode, Instr_dout, npc_in, rec_ready,
        input  rec_valid, rec_enable, rec_instr, rec_npc, rec_ts, count, overflow_cnt
    );

    modport slave (
        input  clear, capture_en, mode, enable_decode, Instr_dout, npc_in, rec_ready,
        output rec_valid, rec_enable, rec_instr, rec_npc, rec_ts, count, overflow_cnt
    );

endinterface

// File: rtl/decode_in_capture_fifo.sv
// Generic synchronous FIFO: async active-low reset, sync clear, registered count.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module decode_in_capture_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    input  logic                         wr_en_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         rd_en_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Head is forced to zero when empty so stale storage never leaks out
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_rd = rd_en_i && !empty_o && !clear_i;
    assign do_wr = wr_en_i && (!full_o || do_rd) && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_wr && !do_rd)      count_d = count_q + 1'b1;
            else if (!do_wr && do_rd) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/decode_in_capture.sv
// Decode-stage input capture: qualifies samples by mode, timestamps them and
// buffers them in a FIFO drained through a valid/ready record port.
module decode_in_capture
    import decode_in_capture_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TS_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    decode_in_capture_if.slave bus
);
    localparam int unsigned REC_W = 1 + 2 * DATA_W + TS_W;

    logic [TS_W-1:0]   ts_q;
    logic [7:0]        ovf_q, ovf_d;
    logic [DATA_W-1:0] last_instr_q, last_instr_d;
    logic [DATA_W-1:0] last_npc_q, last_npc_d;
    logic              last_vld_q, last_vld_d;

    capture_mode_e     mode_sel;
    logic              mode_hit, qualify, pop, push, drop;
    logic              full, empty;
    logic [REC_W-1:0]  wr_rec, rd_rec;

    always_comb begin
        unique case (bus.mode)
            2'b01:   mode_sel = ALL;
            2'b10:   mode_sel = CHANGE;
            default: mode_sel = ENABLED;
        endcase
    end

    always_comb begin
        mode_hit = bus.enable_decode;
        unique case (mode_sel)
            ALL:     mode_hit = 1'b1;
            CHANGE:  mode_hit = bus.enable_decode &&
                                (!last_vld_q || bus.Instr_dout != last_instr_q ||
                                 bus.npc_in != last_npc_q);
            default: mode_hit = bus.enable_decode;
        endcase
    end

    assign qualify = bus.capture_en && mode_hit;
    assign pop     = !empty && bus.rec_ready;
    assign push    = qualify && (!full || pop) && !bus.clear;
    assign drop    = qualify && full && !pop && !bus.clear;

    // Only an accepted push moves the CHANGE reference; drops leave it alone
    always_comb begin
        ovf_d        = ovf_q;
        last_instr_d = last_instr_q;
        last_npc_d   = last_npc_q;
        last_vld_d   = last_vld_q;
        if (bus.clear) begin
            ovf_d      = '0;
            last_vld_d = 1'b0;
        end else begin
            if (drop && ovf_q != OVF_MAX) ovf_d = ovf_q + 1'b1;
            if (push) begin
                last_instr_d = bus.Instr_dout;
                last_npc_d   = bus.npc_in;
                last_vld_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q         <= '0;
            ovf_q        <= '0;
            last_instr_q <= '0;
            last_npc_q   <= '0;
            last_vld_q   <= 1'b0;
        end else begin
            ts_q         <= ts_q + 1'b1;
            ovf_q        <= ovf_d;
            last_instr_q <= last_instr_d;
            last_npc_q   <= last_npc_d;
            last_vld_q   <= last_vld_d;
        end
    end

    assign wr_rec = {bus.enable_decode, bus.Instr_dout, bus.npc_in, ts_q};

    decode_in_capture_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (reset),
        .clear_i   (bus.clear),
        .wr_en_i   (push),
        .wr_data_i (wr_rec),
        .rd_en_i   (pop),
        .rd_data_o (rd_rec),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (bus.count)
    );

    assign bus.rec_valid    = !empty;
    assign bus.rec_enable   = rd_rec[REC_W-1];
    assign bus.rec_instr    = rd_rec[TS_W+2*DATA_W-1 -: DATA_W];
    assign bus.rec_npc      = rd_rec[TS_W+DATA_W-1 -: DATA_W];
    assign bus.rec_ts       = rd_rec[TS_W-1:0];
    assign bus.overflow_cnt = ovf_q;

endmodule
